// File: rtl/temp_alarm_pkg.sv
// Shared types for the temperature alarm controller:
// state codes, streak direction codes and the output decode.
package temp_alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_NOTIFY     = 3'd1,
        ST_FAN        = 3'd2,
        ST_FAN_NOTIFY = 3'd3,
        ST_CRITICAL   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    localparam int unsigned LVL_W = 3;

    // Returns {notif, aban} for a given state.
    function automatic logic [1:0] decode_outs(input state_e st);
        logic [1:0] o;
        o = 2'b00;
        case (st)
            ST_NOTIFY:     o = 2'b10;
            ST_FAN:        o = 2'b01;
            ST_FAN_NOTIFY: o = 2'b11;
            ST_CRITICAL:   o = 2'b11;
            default:       o = 2'b00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/temp_level_classify.sv
// Combinational classifier: maps a sample to its up-level
// and its hysteresis-widened down-level.
module temp_level_classify #(
    parameter int TEMP_W    = 8,
    parameter int THR_NOTIF = 25,
    parameter int THR_FAN   = 27,
    parameter int THR_BOTH  = 30,
    parameter int THR_CRIT  = 37,
    parameter int HYST      = 2
) (
    input  logic [TEMP_W-1:0] temp,
    output logic [2:0]        up_lvl,
    output logic [2:0]        dn_lvl
);

    localparam logic [TEMP_W:0] T_N = (TEMP_W+1)'(THR_NOTIF);
    localparam logic [TEMP_W:0] T_F = (TEMP_W+1)'(THR_FAN);
    localparam logic [TEMP_W:0] T_B = (TEMP_W+1)'(THR_BOTH);
    localparam logic [TEMP_W:0] T_C = (TEMP_W+1)'(THR_CRIT);
    localparam logic [TEMP_W:0] H   = (TEMP_W+1)'(HYST);

    logic [TEMP_W:0] t_up;
    logic [TEMP_W:0] t_dn;

    function automatic logic [2:0] lvl_of(input logic [TEMP_W:0] v);
        logic [2:0] k;
        k = 3'd0;
        if (v >= T_N) k = 3'd1;
        if (v >= T_F) k = 3'd2;
        if (v >= T_B) k = 3'd3;
        if (v >= T_C) k = 3'd4;
        return k;
    endfunction

    // Extra bit keeps temp + HYST from wrapping near full scale.
    assign t_up   = {1'b0, temp};
    assign t_dn   = {1'b0, temp} + H;
    assign up_lvl = lvl_of(t_up);
    assign dn_lvl = lvl_of(t_dn);

endmodule

// File: rtl/temp_alarm_ctrl.sv
// Temperature supervision FSM with persistence filtering,
// downward hysteresis and an acknowledged critical-alarm latch.
module temp_alarm_ctrl
    import temp_alarm_pkg::*;
#(
    parameter int TEMP_W    = 8,
    parameter int THR_NOTIF = 25,
    parameter int THR_FAN   = 27,
    parameter int THR_BOTH  = 30,
    parameter int THR_CRIT  = 37,
    parameter int HYST      = 2,
    parameter int PERSIST   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] temp,
    input  logic              ack,
    output logic              notif,
    output logic              aban,
    output logic              alarm,
    output logic [2:0]        level
);

    localparam int CNT_W = $clog2(PERSIST + 1);

    if (!(THR_NOTIF < THR_FAN && THR_FAN < THR_BOTH &&
          THR_BOTH < THR_CRIT && THR_CRIT < (1 << TEMP_W) &&
          HYST >= 0 && HYST < THR_NOTIF && PERSIST >= 1))
    begin : g_param_err
        $error("temp_alarm_ctrl: illegal parameter set");
    end

    state_e            state_q, state_d;
    dir_e              dir_q, dir_d, new_dir;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              latch_q, latch_d;
    logic [2:0]        up_lvl, dn_lvl;
    logic              qual_up, qual_dn;

    temp_level_classify #(
        .TEMP_W    (TEMP_W),
        .THR_NOTIF (THR_NOTIF),
        .THR_FAN   (THR_FAN),
        .THR_BOTH  (THR_BOTH),
        .THR_CRIT  (THR_CRIT),
        .HYST      (HYST)
    ) u_classify (
        .temp   (temp),
        .up_lvl (up_lvl),
        .dn_lvl (dn_lvl)
    );

    assign qual_up = up_lvl > state_q;
    assign qual_dn = dn_lvl < state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_NONE;
            cnt_q   <= '0;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        new_dir = DIR_NONE;
        cnt_inc = '0;

        if (sample_valid) begin
            unique case (1'b1)
                qual_up: new_dir = DIR_UP;
                qual_dn: new_dir = DIR_DOWN;
                default: new_dir = DIR_NONE;
            endcase

            if (new_dir == DIR_NONE) begin
                cnt_d = '0;
                dir_d = DIR_NONE;
            end else begin
                cnt_inc = (dir_q == new_dir) ? cnt_q + 1'b1
                                             : CNT_W'(1);
                // Target level comes from the completing sample only.
                if (cnt_inc == CNT_W'(PERSIST)) begin
                    state_d = state_e'(qual_up ? up_lvl : dn_lvl);
                    cnt_d   = '0;
                    dir_d   = DIR_NONE;
                end else begin
                    cnt_d = cnt_inc;
                    dir_d = new_dir;
                end
            end
        end

        if (state_d == ST_CRITICAL && state_q != ST_CRITICAL)
            latch_d = 1'b1;
        else if (ack && state_q != ST_CRITICAL)
            latch_d = 1'b0;
    end

    assign {notif, aban} = decode_outs(state_q);
    assign level         = state_q;
    assign alarm         = (state_q == ST_CRITICAL) | latch_q;

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// Bench for temp_alarm_ctrl: directed vector table, an
// asynchronous reset sequence and a randomized reference model.
module tb_temp_alarm_ctrl;

    localparam int HYST    = 2;
    localparam int PERSIST = 3;
    localparam int THR [4] = '{25, 27, 30, 37};

    typedef struct {
        int r;
        int v;
        int t;
        int a;
        int lvl;
        int alm;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       sample_valid;
    logic [7:0] temp;
    logic       ack;
    logic       notif;
    logic       aban;
    logic       alarm;
    logic [2:0] level;

    int checks;
    int errors;

    int m_lvl;
    int m_run;
    int m_latch;

    vec_t vecs[$];

    temp_alarm_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .temp         (temp),
        .ack          (ack),
        .notif        (notif),
        .aban         (aban),
        .alarm        (alarm),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(int r, int v, int t, int a, int lvl, int alm);
        vec_t x;
        x.r = r; x.v = v; x.t = t; x.a = a; x.lvl = lvl; x.alm = alm;
        vecs.push_back(x);
    endtask

    task automatic check(string name, int e_lvl, int e_alm);
        logic e_n, e_a, e_al;
        e_n  = (e_lvl == 1 || e_lvl == 3 || e_lvl == 4);
        e_a  = (e_lvl >= 2);
        e_al = (e_alm != 0);
        checks++;
        if (level !== 3'(e_lvl) || notif !== e_n ||
            aban !== e_a || alarm !== e_al) begin
            errors++;
            $display("FAIL %s: got level=%0d notif=%b aban=%b alarm=%b, expected level=%0d notif=%b aban=%b alarm=%b",
                     name, level, notif, aban, alarm, e_lvl, e_n, e_a, e_al);
        end
    endtask

    task automatic apply(int r, int v, int t, int a);
        @(negedge clk);
        reset        = (r != 0);
        sample_valid = (v != 0);
        temp         = 8'(t);
        ack          = (a != 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int cls(int val);
        int k;
        k = 0;
        for (int i = 0; i < 4; i++)
            if (val >= THR[i]) k = i + 1;
        return k;
    endfunction

    // m_run > 0 counts an upward streak, < 0 a downward one.
    task automatic model_step(int r, int v, int t, int a);
        int old, u, d;
        if (r != 0) begin
            m_lvl = 0; m_run = 0; m_latch = 0;
            return;
        end
        old = m_lvl;
        if (v != 0) begin
            u = cls(t);
            d = cls(t + HYST);
            if (u > m_lvl) begin
                m_run = (m_run > 0) ? m_run + 1 : 1;
                if (m_run == PERSIST) begin m_lvl = u; m_run = 0; end
            end else if (d < m_lvl) begin
                m_run = (m_run < 0) ? m_run - 1 : -1;
                if (-m_run == PERSIST) begin m_lvl = d; m_run = 0; end
            end else begin
                m_run = 0;
            end
        end
        if (m_lvl == 4 && old != 4) m_latch = 1;
        else if (a != 0 && old != 4) m_latch = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        sample_valid = 1'b0;
        temp = 8'd0;
        ack = 1'b0;

        add(1, 0,  0, 0, 0, 0);
        add(0, 1, 28, 0, 0, 0);
        add(0, 1, 28, 0, 0, 0);
        add(0, 1, 28, 0, 2, 0);
        add(0, 1, 28, 0, 2, 0);
        add(0, 1, 31, 0, 2, 0);
        add(0, 1, 31, 0, 2, 0);
        add(0, 1, 20, 0, 2, 0);
        add(0, 1, 26, 0, 2, 0);
        add(0, 1, 26, 0, 2, 0);
        add(0, 1, 26, 0, 2, 0);
        add(0, 1, 24, 0, 2, 0);
        add(0, 1, 24, 0, 2, 0);
        add(0, 1, 24, 0, 1, 0);
        add(0, 1, 30, 0, 1, 0);
        add(0, 1, 30, 0, 1, 0);
        add(0, 1, 30, 0, 3, 0);
        add(0, 1, 29, 0, 3, 0);
        add(0, 1, 29, 0, 3, 0);
        add(0, 1, 29, 0, 3, 0);
        add(0, 1, 27, 0, 3, 0);
        add(0, 1, 27, 0, 3, 0);
        add(0, 1, 27, 0, 2, 0);
        add(0, 1, 40, 0, 2, 0);
        add(0, 1, 40, 0, 2, 0);
        add(0, 1, 40, 0, 4, 1);
        add(0, 1, 40, 1, 4, 1);
        add(0, 1, 20, 0, 4, 1);
        add(0, 1, 20, 0, 4, 1);
        add(0, 1, 20, 0, 0, 1);
        add(0, 0,  0, 1, 0, 0);
        add(0, 1, 40, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 40, 0, 0, 0);
        add(0, 1, 40, 0, 0, 0);
        add(0, 1, 40, 0, 4, 1);
        add(0, 1, 20, 0, 4, 1);
        add(0, 1, 20, 0, 4, 1);
        add(0, 1, 20, 1, 0, 1);
        add(0, 0,  0, 1, 0, 0);
        add(0, 1, 40, 0, 0, 0);
        add(0, 1, 40, 0, 0, 0);
        add(0, 1, 40, 1, 4, 1);
        add(1, 0,  0, 0, 0, 0);
        add(0, 1, 40, 0, 0, 0);
        add(0, 1, 40, 0, 0, 0);
        add(1, 1, 40, 0, 0, 0);
        add(0, 1, 40, 0, 0, 0);
        add(0, 1, 40, 0, 0, 0);
        add(0, 1, 40, 0, 4, 1);
        add(0, 1, 255, 0, 4, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].v, vecs[i].t, vecs[i].a);
            check($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].alm);
        end

        // Reset must clear the outputs before any clock edge.
        @(negedge clk);
        sample_valid = 1'b0;
        ack = 1'b0;
        reset = 1'b1;
        #2;
        check("async_reset", 0, 0);
        @(posedge clk);
        #1;
        check("reset_held", 0, 0);

        // PERSIST-1 samples toward CRITICAL, then leave: must not jump.
        apply(0, 1, 40, 0);
        apply(0, 1, 40, 0);
        check("partial_streak", 0, 0);
        apply(0, 1, 10, 0);
        apply(0, 1, 40, 0);
        check("streak_cleared", 0, 0);

        apply(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        check("rand_reset", m_lvl, m_latch);
        for (int n = 0; n < 4000; n++) begin
            int r, v, t, a;
            r = ($urandom_range(0, 299) == 0) ? 1 : 0;
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(15, 45));
            a = ($urandom_range(0, 7) == 0) ? 1 : 0;
            apply(r, v, t, a);
            model_step(r, v, t, a);
            check("rand", m_lvl, (m_lvl == 4 || m_latch != 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
